vec16_checker: RTL and testbench

Synthesizable, self-checking compare unit for 16-bit gate blocks (Or16, And16, Mux16 and similar). It accepts a stream of (DUT output, expected answer) pairs over a valid/ready handshake. For each pair it produces a registered pass/fail result, and it keeps pass/fail counters and captures the first mismatch. It sits on the far side of the stimulus sequence and checks the results, so the same vector sets can run on FPGA and in simulation without `$display`-based checking.

---
 rtl/chk_pkg.sv | 19 +
 rtl/sat_cnt.sv | 35 +++
 rtl/vec16_checker.sv | 116 +++++++++++
 tb/tb_vec16_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chk_pkg                                                              |
// | Shared types and default widths for the vector compare unit.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package chk_pkg;

  localparam int C_WIDTH_DEF = 16;
  localparam int C_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_cnt                                                              |
// | Up-counter with synchronous clear that sticks at its maximum value.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] C_MAX = '1;

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/vec16_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec16_checker                                                        |
// | Compares a stream of (dut, ans) pairs, pulses a registered result    |
// | per pair, counts pass/fail and captures the first mismatch.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module vec16_checker
  import chk_pkg::*;
#(
  parameter int WIDTH       = C_WIDTH_DEF,
  parameter int CNT_W       = C_CNT_W_DEF,
  parameter int NUM_VECTORS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic [WIDTH-1:0] dut,
  input  logic [WIDTH-1:0] ans,
  output logic             rdy,
  output logic             chk_vld,
  output logic             chk_ok,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_xor,
  output logic             done,
  output logic             all_pass
);

  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] C_IDX_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic             r_chk_vld;
  logic             r_chk_ok;
  logic             r_done;
  logic [CNT_W-1:0] r_ffi;
  logic [WIDTH-1:0] r_ffx;

  logic             w_accept;
  logic             w_match;
  logic [CNT_W-1:0] w_pass_cnt;
  logic [CNT_W-1:0] w_fail_cnt;

  // start takes priority, so a pair offered alongside it is never accepted.
  assign rdy      = (r_state == RUN) && !start;
  assign w_accept = vld && rdy;
  assign w_match  = (dut == ans);

  sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (w_accept && w_match),
    .cnt   (w_pass_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (w_accept && !w_match),
    .cnt   (w_fail_cnt)
  );

  // Run control, per-pair result pulse and first-mismatch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_chk_vld <= 1'b0;
      r_chk_ok  <= 1'b0;
      r_done    <= 1'b0;
      r_ffi     <= '0;
      r_ffx     <= '0;
    end else if (start) begin
      r_state   <= RUN;
      r_idx     <= '0;
      r_chk_vld <= 1'b0;
      r_done    <= 1'b0;
      r_ffi     <= '0;
      r_ffx     <= '0;
    end else begin
      r_chk_vld <= w_accept;
      if (w_accept) begin
        r_chk_ok <= w_match;
        if (r_idx != C_IDX_MAX) begin
          r_idx <= r_idx + 1'b1;
        end
        // A zero fail count before this edge means this is the run's first mismatch.
        if (!w_match && (w_fail_cnt == '0)) begin
          r_ffi <= r_idx;
          r_ffx <= dut ^ ans;
        end
        if (r_idx == C_LAST) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign chk_vld        = r_chk_vld;
  assign chk_ok         = r_chk_ok;
  assign pass_cnt       = w_pass_cnt;
  assign fail_cnt       = w_fail_cnt;
  assign first_fail_idx = r_ffi;
  assign first_fail_xor = r_ffx;
  assign done           = r_done;
  assign all_pass       = r_done && (w_fail_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_vec16_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vec16_checker                                                     |
// | Randomized self-checking bench for vec16_checker.                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_vec16_checker;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] dut_v = '0;
  logic [15:0] ans_v = '0;
  logic        rdy, chk_vld, chk_ok, done, all_pass;
  logic [7:0]  pass_cnt, fail_cnt, first_fail_idx;
  logic [15:0] first_fail_xor;

  int errors = 0;
  int checks = 0;

  // vectors for the current run and the reference results derived from them
  logic [15:0] vd [N];
  logic [15:0] va [N];
  bit          m_ok [N];
  int          m_pass, m_fail, m_ffi;
  logic [15:0] m_ffx;

  // results observed on the result pulse, one entry per pulse cycle
  bit obs_ok [$];
  bit obs_done [$];

  vec16_checker #(.WIDTH(16), .CNT_W(8), .NUM_VECTORS(N)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vld            (vld),
    .dut            (dut_v),
    .ans            (ans_v),
    .rdy            (rdy),
    .chk_vld        (chk_vld),
    .chk_ok         (chk_ok),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_xor (first_fail_xor),
    .done           (done),
    .all_pass       (all_pass)
  );

  always #5 clk = ~clk;

  // record every result pulse mid-cycle
  always @(negedge clk) begin
    if (chk_vld) begin
      obs_ok.push_back(chk_ok);
      obs_done.push_back(done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: a pair passes iff the two words are equal; first unequal pair is captured
  task automatic model();
    m_pass = 0; m_fail = 0; m_ffi = 0; m_ffx = '0;
    for (int i = 0; i < N; i++) begin
      m_ok[i] = (vd[i] == va[i]);
      if (m_ok[i]) m_pass++;
      else begin
        if (m_fail == 0) begin
          m_ffi = i;
          m_ffx = vd[i] ^ va[i];
        end
        m_fail++;
      end
    end
  endtask

  task automatic rand_vectors(input int fail_odds);
    for (int i = 0; i < N; i++) begin
      va[i] = 16'($urandom);
      vd[i] = ($urandom_range(0, fail_odds) == 0) ? (va[i] ^ (16'd1 << $urandom_range(0, 15))) : va[i];
    end
  endtask

  task automatic run(input bit do_start, input int gap);
    obs_ok.delete();
    obs_done.delete();
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      vld = 1'b1; dut_v = vd[i]; ans_v = va[i];
      step();
      vld = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
    vld = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    checks++; if (chk_vld !== 1'b0 || chk_ok !== 1'b0) begin errors++; $display("FAIL reset_chk: got vld=%b ok=%b want 0 0", chk_vld, chk_ok); end
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
    checks++; if (first_fail_idx !== 8'd0 || first_fail_xor !== 16'h0) begin errors++; $display("FAIL reset_cap: got %0d %h want 0 0000", first_fail_idx, first_fail_xor); end
    checks++; if (done !== 1'b0 || all_pass !== 1'b0) begin errors++; $display("FAIL reset_done: got %b %b want 0 0", done, all_pass); end
    rst_n = 1'b1;
    // vld while idle must not be accepted
    obs_ok.delete();
    vld = 1'b1; dut_v = 16'h1234; ans_v = 16'h1234;
    repeat (3) step();
    vld = 1'b0;
    checks++; if (obs_ok.size() != 0 || rdy !== 1'b0) begin errors++; $display("FAIL idle_vld: got pulses=%0d rdy=%b want 0 0", obs_ok.size(), rdy); end
  endtask

  task automatic test_all_pass();
    logic [15:0] a, b;
    for (int i = 0; i < N; i++) begin
      a = (i == 0) ? 16'b1010101010101010 : 16'($urandom);
      b = (i == 0) ? 16'b0101010101010101 : 16'($urandom);
      va[i] = a | b;
      vd[i] = a | b;
    end
    model();
    run(1'b1, 0);
    checks++; if (obs_ok.size() != N) begin errors++; $display("FAIL allpass_pulses: got %0d want %0d", obs_ok.size(), N); end
    for (int i = 0; i < N && i < obs_ok.size(); i++) begin
      checks++; if (obs_ok[i] !== 1'b1) begin errors++; $display("FAIL allpass_ok[%0d]: got %b want 1", i, obs_ok[i]); end
    end
    checks++; if (pass_cnt !== 8'd6 || fail_cnt !== 8'd0) begin errors++; $display("FAIL allpass_cnt: got %0d/%0d want 6/0", pass_cnt, fail_cnt); end
    checks++; if (done !== 1'b1 || all_pass !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL allpass_done: got done=%b all=%b rdy=%b want 1 1 0", done, all_pass, rdy); end
  endtask

  task automatic test_single_mismatch();
    rand_vectors(1000000);
    for (int i = 0; i < N; i++) vd[i] = va[i];
    vd[4] = 16'h3FF2; va[4] = 16'h3FF3;
    model();
    run(1'b1, 0);
    checks++; if (obs_ok.size() != N) begin errors++; $display("FAIL single_pulses: got %0d want %0d", obs_ok.size(), N); end
    for (int i = 0; i < N && i < obs_ok.size(); i++) begin
      checks++; if (obs_ok[i] !== m_ok[i]) begin errors++; $display("FAIL single_ok[%0d]: got %b want %b", i, obs_ok[i], m_ok[i]); end
    end
    checks++; if (fail_cnt !== 8'd1 || pass_cnt !== 8'd5) begin errors++; $display("FAIL single_cnt: got %0d/%0d want 5/1", pass_cnt, fail_cnt); end
    checks++; if (first_fail_idx !== 8'd4 || first_fail_xor !== 16'h0001) begin errors++; $display("FAIL single_cap: got %0d %h want 4 0001", first_fail_idx, first_fail_xor); end
    checks++; if (done !== 1'b1 || all_pass !== 1'b0) begin errors++; $display("FAIL single_done: got %b %b want 1 0", done, all_pass); end
  endtask

  task automatic test_two_mismatch();
    rand_vectors(1000000);
    for (int i = 0; i < N; i++) vd[i] = va[i];
    vd[1] = va[1] ^ 16'h8000;
    vd[3] = va[3] ^ 16'h00FF;
    model();
    run(1'b1, 0);
    checks++; if (fail_cnt !== 8'd2 || pass_cnt !== 8'(m_pass)) begin errors++; $display("FAIL two_cnt: got %0d/%0d want %0d/2", pass_cnt, fail_cnt, m_pass); end
    checks++; if (first_fail_idx !== 8'd1 || first_fail_xor !== 16'h8000) begin errors++; $display("FAIL two_cap: got %0d %h want 1 8000", first_fail_idx, first_fail_xor); end
    for (int i = 0; i < N && i < obs_ok.size(); i++) begin
      checks++; if (obs_ok[i] !== m_ok[i]) begin errors++; $display("FAIL two_ok[%0d]: got %b want %b", i, obs_ok[i], m_ok[i]); end
    end
  endtask

  task automatic test_gapped();
    rand_vectors(2);
    model();
    run(1'b1, 1);
    checks++; if (obs_ok.size() != N) begin errors++; $display("FAIL gap_pulses: got %0d want %0d", obs_ok.size(), N); end
    if (obs_done.size() == N) begin
      checks++; if (obs_done[N-2] !== 1'b0 || obs_done[N-1] !== 1'b1) begin errors++; $display("FAIL gap_done_edge: got %b%b want 01", obs_done[N-2], obs_done[N-1]); end
    end
    checks++; if (pass_cnt !== 8'(m_pass) || fail_cnt !== 8'(m_fail)) begin errors++; $display("FAIL gap_cnt: got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, m_pass, m_fail); end
    obs_ok.delete();
    vld = 1'b1; dut_v = 16'h0F0F; ans_v = 16'h0F0F;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL gap_after_rdy: got %b want 0", rdy); end
    repeat (3) step();
    vld = 1'b0;
    checks++; if (obs_ok.size() != 0 || pass_cnt !== 8'(m_pass)) begin errors++; $display("FAIL gap_after_pulse: got pulses=%0d pass=%0d want 0 %0d", obs_ok.size(), pass_cnt, m_pass); end
  endtask

  task automatic test_restart();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; dut_v = 16'h00AA; ans_v = (i == 1) ? 16'h00AB : 16'h00AA;
      step();
    end
    // collide start with a mismatching pair
    start = 1'b1; vld = 1'b1; dut_v = 16'hFFFF; ans_v = 16'h0000;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL restart_rdy: got %b want 0", rdy); end
    step();
    start = 1'b0; vld = 1'b0;
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || chk_vld !== 1'b0) begin errors++; $display("FAIL restart_clear: got %0d/%0d vld=%b want 0/0 0", pass_cnt, fail_cnt, chk_vld); end
    checks++; if (first_fail_idx !== 8'd0 || first_fail_xor !== 16'h0) begin errors++; $display("FAIL restart_cap: got %0d %h want 0 0000", first_fail_idx, first_fail_xor); end
    rand_vectors(1000000);
    for (int i = 0; i < N; i++) vd[i] = va[i];
    vd[2] = va[2] ^ 16'h0100;
    model();
    run(1'b0, 0);
    checks++; if (obs_ok.size() != N || done !== 1'b1) begin errors++; $display("FAIL restart_run: got pulses=%0d done=%b want %0d 1", obs_ok.size(), done, N); end
    checks++; if (first_fail_idx !== 8'(m_ffi) || fail_cnt !== 8'(m_fail) || pass_cnt !== 8'(m_pass)) begin errors++; $display("FAIL restart_idx: got idx=%0d cnt=%0d/%0d want %0d %0d/%0d", first_fail_idx, pass_cnt, fail_cnt, m_ffi, m_pass, m_fail); end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld = 1'b1; dut_v = 16'h5555; ans_v = (i == 0) ? 16'h5554 : 16'h5555;
      step();
    end
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (chk_vld !== 1'b0 || chk_ok !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL midrst_chk: got vld=%b ok=%b rdy=%b want 0 0 0", chk_vld, chk_ok, rdy); end
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || first_fail_xor !== 16'h0 || first_fail_idx !== 8'd0) begin errors++; $display("FAIL midrst_cnt: got %0d/%0d %0d %h want 0/0 0 0000", pass_cnt, fail_cnt, first_fail_idx, first_fail_xor); end
    checks++; if (done !== 1'b0 || all_pass !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b %b want 0 0", done, all_pass); end
    step();
    rst_n = 1'b1;
    obs_ok.delete();
    vld = 1'b1; dut_v = 16'h1111; ans_v = 16'h1111;
    repeat (4) step();
    vld = 1'b0;
    checks++; if (obs_ok.size() != 0 || pass_cnt !== 8'd0) begin errors++; $display("FAIL midrst_after: got pulses=%0d pass=%0d want 0 0", obs_ok.size(), pass_cnt); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      rand_vectors(r % 4);
      model();
      run(1'b1, int'($urandom_range(0, 2)));
      checks++; if (obs_ok.size() != N) begin errors++; $display("FAIL rand%0d_pulses: got %0d want %0d", r, obs_ok.size(), N); end
      for (int i = 0; i < N && i < obs_ok.size(); i++) begin
        checks++; if (obs_ok[i] !== m_ok[i]) begin errors++; $display("FAIL rand%0d_ok[%0d]: got %b want %b", r, i, obs_ok[i], m_ok[i]); end
      end
      checks++; if (pass_cnt !== 8'(m_pass) || fail_cnt !== 8'(m_fail)) begin errors++; $display("FAIL rand%0d_cnt: got %0d/%0d want %0d/%0d", r, pass_cnt, fail_cnt, m_pass, m_fail); end
      checks++; if (first_fail_idx !== 8'(m_ffi) || first_fail_xor !== m_ffx) begin errors++; $display("FAIL rand%0d_cap: got %0d %h want %0d %h", r, first_fail_idx, first_fail_xor, m_ffi, m_ffx); end
      checks++; if (done !== 1'b1 || all_pass !== (m_fail == 0)) begin errors++; $display("FAIL rand%0d_done: got %b %b want 1 %b", r, done, all_pass, (m_fail == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_single_mismatch();
    test_two_mismatch();
    test_gapped();
    test_restart();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
